// File: rtl/cfg_reg_pkg.sv
// rtl/cfg_reg_pkg.sv - shared constants and types for the config register arbiter
package cfg_reg_pkg;

   localparam int CFG_ADDR_W = 7;
   localparam int CFG_DATA_W = 8;

   localparam logic [CFG_ADDR_W-1:0] REG_OUT_LO = 7'h00;
   localparam logic [CFG_ADDR_W-1:0] REG_OUT_HI = 7'h01;
   localparam logic [CFG_ADDR_W-1:0] REG_PWM_LO = 7'h02;
   localparam logic [CFG_ADDR_W-1:0] REG_PWM_HI = 7'h03;
   localparam logic [CFG_ADDR_W-1:0] REG_DUTY   = 7'h04;
   localparam logic [CFG_ADDR_W-1:0] LOCK_ADDR  = 7'h05;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ADDR    = 2'b01;
   localparam logic [1:0] ERR_LOCK    = 2'b10;
   localparam logic [1:0] ERR_LOCKREG = 2'b11;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

   typedef struct packed {
      logic                  valid;
      src_e                  src;
      logic [CFG_ADDR_W-1:0] addr;
      logic [CFG_DATA_W-1:0] data;
   } stage_t;

endpackage

// File: rtl/cfg_reg_arbiter_rr_arb2.sv
// rtl/cfg_reg_arbiter_rr_arb2.sv - two-requester round-robin arbiter
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic prefer_b_q;
   logic prefer_b_d;

   always_comb begin
      if (req == 2'b11) begin
         gnt = prefer_b_q ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end

   // After granting A, B gets the next tie, and vice versa.
   always_comb begin
      prefer_b_d = prefer_b_q;
      if (advance) begin
         prefer_b_d = gnt[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prefer_b_q <= 1'b0;
      end else begin
         prefer_b_q <= prefer_b_d;
      end
   end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// rtl/cfg_reg_arbiter.sv - config register bank with A/B write arbitration and stallable commit
module cfg_reg_arbiter
   import cfg_reg_pkg::*;
#(
   parameter int                 ADDR_W    = CFG_ADDR_W,
   parameter int                 DATA_W    = CFG_DATA_W,
   parameter logic [ADDR_W-1:0]  LOCK_ADDR = cfg_reg_pkg::LOCK_ADDR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              hold,
   output logic [DATA_W-1:0] en_reg_out_7_0,
   output logic [DATA_W-1:0] en_reg_out_15_8,
   output logic [DATA_W-1:0] en_reg_pwm_7_0,
   output logic [DATA_W-1:0] en_reg_pwm_15_8,
   output logic [DATA_W-1:0] pwm_duty_cycle,
   output logic              cfg_locked,
   output logic              err_valid,
   output logic [1:0]        err_code
);

   stage_t                  stage_q, stage_d;
   logic [4:0][DATA_W-1:0]  regs_q, regs_d;
   logic                    locked_q, locked_d;
   logic                    err_valid_q, err_valid_d;
   logic [1:0]              err_code_q, err_code_d;
   logic                    can_accept;
   logic                    commit;
   logic [1:0]              gnt;

   assign can_accept = !stage_q.valid || !hold;
   assign commit     = stage_q.valid && !hold;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({b_valid, a_valid} & {2{can_accept}}),
      .advance (|gnt),
      .gnt     (gnt)
   );

   assign a_ready = gnt[0];
   assign b_ready = gnt[1];

   // An accept on the commit edge reloads the stage, so there is no bubble.
   always_comb begin
      stage_d = stage_q;
      if (commit) begin
         stage_d.valid = 1'b0;
      end
      if (gnt[0]) begin
         stage_d = '{valid: 1'b1, src: SRC_A, addr: a_addr, data: a_data};
      end else if (gnt[1]) begin
         stage_d = '{valid: 1'b1, src: SRC_B, addr: b_addr, data: b_data};
      end
   end

   // Lock state is evaluated at commit time, not when the entry was accepted.
   always_comb begin
      regs_d      = regs_q;
      locked_d    = locked_q;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      if (commit) begin
         if (stage_q.addr <= REG_DUTY) begin
            if (stage_q.src == SRC_B && locked_q) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_LOCK;
            end else begin
               regs_d[stage_q.addr[2:0]] = stage_q.data;
            end
         end else if (stage_q.addr == LOCK_ADDR) begin
            if (stage_q.src == SRC_A) begin
               locked_d = stage_q.data[0];
            end else begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_LOCKREG;
            end
         end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_ADDR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q     <= '0;
         regs_q      <= '0;
         locked_q    <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         stage_q     <= stage_d;
         regs_q      <= regs_d;
         locked_q    <= locked_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   assign en_reg_out_7_0  = regs_q[0];
   assign en_reg_out_15_8 = regs_q[1];
   assign en_reg_pwm_7_0  = regs_q[2];
   assign en_reg_pwm_15_8 = regs_q[3];
   assign pwm_duty_cycle  = regs_q[4];
   assign cfg_locked      = locked_q;
   assign err_valid       = err_valid_q;
   assign err_code        = err_code_q;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// tb/tb_cfg_reg_arbiter.sv - self-checking bench for cfg_reg_arbiter against a queue-based model
module tb_cfg_reg_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_valid, b_valid, hold;
   logic [6:0] a_addr, b_addr;
   logic [7:0] a_data, b_data;
   logic       a_ready, b_ready;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       cfg_locked, err_valid;
   logic [1:0] err_code;

   always #5 clk = ~clk;

   cfg_reg_arbiter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .a_valid         (a_valid),
      .a_addr          (a_addr),
      .a_data          (a_data),
      .a_ready         (a_ready),
      .b_valid         (b_valid),
      .b_addr          (b_addr),
      .b_data          (b_data),
      .b_ready         (b_ready),
      .hold            (hold),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .cfg_locked      (cfg_locked),
      .err_valid       (err_valid),
      .err_code        (err_code)
   );

   typedef struct {
      bit      src_b;
      int      addr;
      int      data;
   } ent_t;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] m_reg [5];
   logic       m_lock;
   logic       m_errv;
   logic [1:0] m_errc;
   bit         m_last_b;
   ent_t       pend [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_reg[i]) m_reg[i] = 8'h00;
      m_lock   = 1'b0;
      m_errv   = 1'b0;
      m_errc   = 2'b00;
      m_last_b = 1'b1;
      pend.delete();
   endtask

   task automatic model_commit(input ent_t e);
      if (e.addr < 5) begin
         if (e.src_b && m_lock) begin
            m_errv = 1'b1; m_errc = 2'd2;
         end else begin
            m_reg[e.addr] = e.data[7:0];
         end
      end else if (e.addr == 5) begin
         if (!e.src_b) m_lock = e.data[0];
         else begin
            m_errv = 1'b1; m_errc = 2'd3;
         end
      end else begin
         m_errv = 1'b1; m_errc = 2'd1;
      end
   endtask

   task automatic check_outs();
      chk("out_lo",    en_reg_out_7_0,  m_reg[0]);
      chk("out_hi",    en_reg_out_15_8, m_reg[1]);
      chk("pwm_lo",    en_reg_pwm_7_0,  m_reg[2]);
      chk("pwm_hi",    en_reg_pwm_15_8, m_reg[3]);
      chk("duty",      pwm_duty_cycle,  m_reg[4]);
      chk("locked",    cfg_locked,      m_lock);
      chk("err_valid", err_valid,       m_errv);
      chk("err_code",  err_code,        m_errc);
   endtask

   // Inputs are driven at the falling edge; the task returns at the next falling edge.
   task automatic cycle(output bit ga, output bit gb);
      bit   can;
      ent_t ea, eb;
      #1;
      can = (pend.size() == 0) || !hold;
      ga  = 1'b0;
      gb  = 1'b0;
      if (can) begin
         if (a_valid && b_valid) begin
            if (m_last_b) ga = 1'b1;
            else          gb = 1'b1;
         end else begin
            ga = a_valid;
            gb = b_valid;
         end
      end
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      chk("one_ready", a_ready && b_ready, 1'b0);
      ea = '{1'b0, int'(a_addr), int'(a_data)};
      eb = '{1'b1, int'(b_addr), int'(b_data)};
      @(posedge clk);
      m_errv = 1'b0;
      if (pend.size() > 0 && !hold) model_commit(pend.pop_front());
      if (ga) begin pend.push_back(ea); m_last_b = 1'b0; end
      if (gb) begin pend.push_back(eb); m_last_b = 1'b1; end
      @(negedge clk);
      check_outs();
   endtask

   task automatic idle(input int n);
      bit ga, gb;
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle(ga, gb);
   endtask

   task automatic wr(input bit port_b, input int addr, input int data);
      bit ga, gb, done;
      done = 1'b0;
      if (port_b) begin b_valid = 1'b1; b_addr = 7'(addr); b_data = 8'(data); end
      else        begin a_valid = 1'b1; a_addr = 7'(addr); a_data = 8'(data); end
      for (int i = 0; i < 10 && !done; i++) begin
         cycle(ga, gb);
         done = port_b ? gb : ga;
      end
      chk("wr_accepted", done, 1'b1);
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   function automatic logic [6:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r <= 7) return 7'(r);
      if (r == 8) return 7'($urandom_range(8, 127));
      return 7'd5;
   endfunction

   initial begin
      bit ga, gb, a_go, b_go;
      int ai, bi;
      logic [6:0] la [2];
      logic [7:0] lda [2];
      logic [6:0] lb [2];
      logic [7:0] ldb [2];

      rst_n = 1'b0; hold = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outs();
      rst_n = 1'b1;

      // Scenario 1: A writes duty, visible one edge after acceptance.
      wr(1'b0, 4, 8'h80);
      chk("t1_not_yet", pwm_duty_cycle, 8'h00);
      idle(1);
      chk("t1_duty", pwm_duty_cycle, 8'h80);

      // Scenario 2: prime pointer with a B write, then tie every cycle.
      wr(1'b1, 3, 8'h07);
      idle(1);
      la  = '{7'h00, 7'h01}; lda = '{8'h11, 8'h22};
      lb  = '{7'h02, 7'h03}; ldb = '{8'h33, 8'h44};
      ai = 0; bi = 0;
      for (int k = 0; k < 4; k++) begin
         a_valid = (ai < 2); if (ai < 2) begin a_addr = la[ai]; a_data = lda[ai]; end
         b_valid = (bi < 2); if (bi < 2) begin b_addr = lb[bi]; b_data = ldb[bi]; end
         cycle(ga, gb);
         chk("t2_alt", gb, 32'(k % 2));
         if (ga) ai++;
         if (gb) bi++;
      end
      idle(1);
      chk("t2_r0", en_reg_out_7_0, 8'h11);
      chk("t2_r3", en_reg_pwm_15_8, 8'h44);

      // Scenario 3: hold with an entry staged blocks the next request.
      hold = 1'b1;
      wr(1'b0, 0, 8'hFF);
      a_valid = 1'b1; a_addr = 7'h01; a_data = 8'h5A;
      for (int k = 0; k < 3; k++) begin
         cycle(ga, gb);
         chk("t3_blocked", ga, 1'b0);
      end
      chk("t3_hold_reg", en_reg_out_7_0, 8'h11);
      hold = 1'b0;
      cycle(ga, gb);
      chk("t3_reg", en_reg_out_7_0, 8'hFF);
      idle(1);

      // Scenario 4: lock then B write denied.
      wr(1'b0, 5, 8'h01);
      wr(1'b1, 2, 8'h55);
      idle(1);
      chk("t4_errv", err_valid, 1'b1);
      chk("t4_code", err_code, 2'b10);
      chk("t4_reg", en_reg_pwm_7_0, 8'h33);
      chk("t4_lock", cfg_locked, 1'b1);

      // Scenario 5: B to lock register, A to a bad address.
      wr(1'b1, 5, 8'h00);
      idle(1);
      chk("t5_code_lock", err_code, 2'b11);
      wr(1'b0, 7'h10, 8'h12);
      idle(1);
      chk("t5_code_addr", err_code, 2'b01);
      idle(1);
      chk("t5_code_held", err_code, 2'b01);

      // Scenario 6: reset while an entry is staged.
      hold = 1'b1;
      wr(1'b0, 4, 8'h77);
      rst_n = 1'b0;
      model_reset();
      #1 check_outs();
      @(negedge clk);
      check_outs();
      hold = 1'b0;
      rst_n = 1'b1;
      a_valid = 1'b1; a_addr = 7'h00; a_data = 8'h01;
      b_valid = 1'b1; b_addr = 7'h01; b_data = 8'h02;
      cycle(ga, gb);
      chk("t6_tie_a", ga, 1'b1);
      a_valid = 1'b0;
      cycle(ga, gb);
      idle(2);

      // Random traffic; requesters hold requests until accepted.
      a_go = 1'b1; b_go = 1'b1;
      for (int k = 0; k < 400; k++) begin
         if (a_go) begin
            a_valid = ($urandom_range(0, 9) < 6);
            a_addr  = rand_addr();
            a_data  = 8'($urandom);
         end
         if (b_go) begin
            b_valid = ($urandom_range(0, 9) < 6);
            b_addr  = rand_addr();
            b_data  = 8'($urandom);
         end
         hold = ($urandom_range(0, 3) == 0);
         cycle(ga, gb);
         a_go = ga || !a_valid;
         b_go = gb || !b_valid;
      end
      hold = 1'b0;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
